// File: rtl/alu_input_sequencer_if.sv
// Pin-side bundle for the ALU input sequencer: switches, raw buttons, ALU result in;
// registered operands, opcode, captured result and FSM state out.
interface alu_input_sequencer_if #(
    parameter int OP_CODE_SIZE = 6,
    parameter int OPERAND_SIZE = 8
);
    logic [OPERAND_SIZE-1:0] i_switches;
    logic                    i_btn_A;
    logic                    i_btn_B;
    logic                    i_btn_OP;
    logic [OPERAND_SIZE:0]   i_alu_result;
    logic [OPERAND_SIZE-1:0] o_data_a;
    logic [OPERAND_SIZE-1:0] o_data_b;
    logic [OP_CODE_SIZE-1:0] o_op;
    logic [OPERAND_SIZE:0]   o_result;
    logic                    o_result_valid;
    logic [2:0]              o_state;

    // Board/pin side: drives switches, buttons and the ALU result.
    modport master (
        output i_switches, i_btn_A, i_btn_B, i_btn_OP, i_alu_result,
        input  o_data_a, o_data_b, o_op, o_result, o_result_valid, o_state
    );

    modport slave (
        input  i_switches, i_btn_A, i_btn_B, i_btn_OP, i_alu_result,
        output o_data_a, o_data_b, o_op, o_result, o_result_valid, o_state
    );
endinterface

// File: rtl/alu_input_sequencer.sv
// Debounces three push buttons and walks the ALU through load A, load B, load opcode,
// then a one-cycle execute whose result is held stable for the LEDs.
module alu_input_sequencer #(
    parameter int OP_CODE_SIZE    = 6,
    parameter int OPERAND_SIZE    = 8,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    alu_input_sequencer_if.slave  bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_RES  = 3'd4
    } state_e;

    // Bit 0 = A, bit 1 = B, bit 2 = OP throughout the debounce path.
    logic [2:0] raw;
    logic [2:0] s1_q, s1_d, s2_q, s2_d;
    logic [2:0] stable_q, stable_d, stable_dly_q, stable_dly_d;
    logic [2:0] press;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];

    state_e                  state_q, state_d;
    logic [OPERAND_SIZE-1:0] data_a_q, data_a_d;
    logic [OPERAND_SIZE-1:0] data_b_q, data_b_d;
    logic [OP_CODE_SIZE-1:0] op_q, op_d;
    logic [OPERAND_SIZE:0]   result_q, result_d;
    logic                    valid_q, valid_d;

    assign raw = {bus.i_btn_OP, bus.i_btn_B, bus.i_btn_A};

    always_comb begin
        s1_d         = raw;
        s2_d         = s1_q;
        stable_d     = stable_q;
        stable_dly_d = stable_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        press = stable_q & ~stable_dly_q;
    end

    // Only the press matching the current state acts; all others are dropped.
    always_comb begin
        state_d  = state_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        op_d     = op_q;
        result_d = result_q;
        valid_d  = valid_q;
        case (state_q)
            S_A: begin
                if (press[0]) begin
                    data_a_d = bus.i_switches;
                    state_d  = S_B;
                end
            end
            S_B: begin
                if (press[1]) begin
                    data_b_d = bus.i_switches;
                    state_d  = S_OP;
                end
            end
            S_OP: begin
                if (press[2]) begin
                    op_d    = bus.i_switches[OP_CODE_SIZE-1:0];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                result_d = bus.i_alu_result;
                valid_d  = 1'b1;
                state_d  = S_RES;
            end
            S_RES: begin
                if (press[0]) begin
                    data_a_d = bus.i_switches;
                    valid_d  = 1'b0;
                    state_d  = S_B;
                end
            end
            default: state_d = S_A;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_q         <= '0;
            s2_q         <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            state_q      <= S_A;
            data_a_q     <= '0;
            data_b_q     <= '0;
            op_q         <= '0;
            result_q     <= '0;
            valid_q      <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
            state_q      <= state_d;
            data_a_q     <= data_a_d;
            data_b_q     <= data_b_d;
            op_q         <= op_d;
            result_q     <= result_d;
            valid_q      <= valid_d;
        end
    end

    assign bus.o_data_a       = data_a_q;
    assign bus.o_data_b       = data_b_q;
    assign bus.o_op           = op_q;
    assign bus.o_result       = result_q;
    assign bus.o_result_valid = valid_q;
    assign bus.o_state        = state_q;
endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed and randomized button sequences against a transaction-level model of the
// A -> B -> OP -> execute -> result flow, with cycle-exact debounce latency checks.
module tb_alu_input_sequencer;
    localparam int D = 4;

    logic i_clk;
    logic i_rst_n;
    int   total = 0;
    int   bad   = 0;

    alu_input_sequencer_if #(.OP_CODE_SIZE(6), .OPERAND_SIZE(8)) bus ();

    alu_input_sequencer #(
        .OP_CODE_SIZE(6),
        .OPERAND_SIZE(8),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    // Board ALU stand-in: plain 9-bit add of the registered operands.
    assign bus.i_alu_result = {1'b0, bus.o_data_a} + {1'b0, bus.o_data_b};

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference model: state number 0..4 and the values the outputs should show.
    int         m_state;
    logic [7:0] m_a, m_b;
    logic [5:0] m_op;
    logic [8:0] m_res;
    logic       m_valid;

    function automatic void model_reset();
        m_state = 0; m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_valid = 1'b0;
    endfunction

    function automatic void model_press(input logic [2:0] mask, input logic [7:0] sw);
        case (m_state)
            0: if (mask[0]) begin m_a = sw; m_state = 1; end
            1: if (mask[1]) begin m_b = sw; m_state = 2; end
            2: if (mask[2]) begin m_op = sw[5:0]; m_state = 3; end
            4: if (mask[0]) begin m_a = sw; m_valid = 1'b0; m_state = 1; end
            default: ;
        endcase
    endfunction

    function automatic void model_exec();
        if (m_state == 3) begin
            m_res   = {1'b0, m_a} + {1'b0, m_b};
            m_valid = 1'b1;
            m_state = 4;
        end
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_state"}, 32'(bus.o_state), 32'(m_state));
        check({tag, "_a"},     32'(bus.o_data_a), 32'(m_a));
        check({tag, "_b"},     32'(bus.o_data_b), 32'(m_b));
        check({tag, "_op"},    32'(bus.o_op), 32'(m_op));
        check({tag, "_res"},   32'(bus.o_result), 32'(m_res));
        check({tag, "_valid"}, 32'(bus.o_result_valid), 32'(m_valid));
    endtask

    task automatic set_btns(input logic [2:0] mask);
        bus.i_btn_A  = mask[0];
        bus.i_btn_B  = mask[1];
        bus.i_btn_OP = mask[2];
    endtask

    // Hold the buttons for 10 cycles; the press must act exactly D+3 edges after the
    // first sampling edge, and not one edge earlier.
    task automatic press(input logic [2:0] mask, input logic [7:0] sw, input string tag);
        bus.i_switches = sw;
        set_btns(mask);
        for (int i = 0; i < D + 2; i++) tick();
        check_all({tag, "_pre"});
        tick();
        model_press(mask, sw);
        check_all(tag);
        bus.i_switches = 8'($urandom);
        tick();
        model_exec();
        check_all({tag, "_post"});
        tick();
        tick();
        set_btns(3'b000);
        for (int i = 0; i < D + 5; i++) tick();
        check_all({tag, "_idle"});
    endtask

    task automatic do_reset(input string tag);
        i_rst_n = 1'b0;
        set_btns(3'b000);
        tick();
        model_reset();
        check_all(tag);
        i_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        i_rst_n        = 1'b0;
        bus.i_switches = '0;
        set_btns(3'b000);
        model_reset();
        tick();
        tick();
        check_all("rst_idle");

        // Buttons held high through reset: exactly one A press after release.
        set_btns(3'b111);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("rst_hold_in");
        end
        i_rst_n = 1'b1;
        press(3'b111, 8'h5A, "rst_hold");
        check("rst_hold_a", 32'(bus.o_data_a), 32'h5A);

        // Glitch of D-1 cycles is rejected, a long hold is accepted.
        do_reset("rst2");
        bus.i_switches = 8'h77;
        bus.i_btn_A = 1'b1;
        for (int i = 0; i < D - 1; i++) tick();
        bus.i_btn_A = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_all("glitch");
        check("glitch_state", 32'(bus.o_state), 32'd0);
        press(3'b001, 8'hC3, "glitch_hold");

        // Full sequence with fixed values.
        do_reset("rst3");
        press(3'b001, 8'h25, "full_a");
        press(3'b010, 8'h13, "full_b");
        press(3'b100, 8'h20, "full_op");
        check("full_result", 32'(bus.o_result), 32'h038);
        check("full_valid", 32'(bus.o_result_valid), 32'd1);
        check("full_state", 32'(bus.o_state), 32'd4);

        // Carry bit captured at full width.
        press(3'b001, 8'hFF, "carry_a");
        press(3'b010, 8'h01, "carry_b");
        press(3'b100, 8'h07, "carry_op");
        check("carry_result", 32'(bus.o_result), 32'h100);

        // Out-of-order and simultaneous presses.
        do_reset("rst4");
        press(3'b010, 8'h11, "ooo_b_in_a");
        press(3'b100, 8'h22, "ooo_op_in_a");
        check("ooo_state", 32'(bus.o_state), 32'd0);
        press(3'b001, 8'h33, "ooo_a");
        press(3'b011, 8'h44, "sim_ab");
        check("sim_a_kept", 32'(bus.o_data_a), 32'h33);
        check("sim_b_load", 32'(bus.o_data_b), 32'h44);
        press(3'b100, 8'h05, "ooo_op");

        // Restart from the result state, then reset in the middle of an operation.
        press(3'b001, 8'h0F, "restart_a");
        check("restart_valid", 32'(bus.o_result_valid), 32'd0);
        check("restart_data_a", 32'(bus.o_data_a), 32'h0F);
        check("restart_res", 32'(bus.o_result), 32'h077);
        press(3'b010, 8'h09, "restart_b");
        i_rst_n = 1'b0;
        tick();
        model_reset();
        check_all("midop_rst");
        check("midop_state", 32'(bus.o_state), 32'd0);
        i_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Random press masks and switch values.
        for (int n = 0; n < 20; n++) begin
            press(3'($urandom_range(1, 7)), 8'($urandom), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_input_sequencer.md
Name: alu_input_sequencer

Overview:
- Controller that sequences the board-level ALU from three push buttons and the operand switches.
- Debounces and edge-detects btnL/btnC/btnR-class inputs, then enforces an ordered load: operand A, then operand B, then opcode, then one-cycle execute.
- Drives the ALU operand/opcode inputs from internal registers and captures the ALU result into a registered, stable LED-facing output.
- Sits between the top-level pins and the combinational ALU datapath.

Parameters:
- OP_CODE_SIZE, 6, opcode width taken from i_switches[OP_CODE_SIZE-1:0]
- OPERAND_SIZE, 8, operand width; result width is OPERAND_SIZE+1
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a button level change (must be >= 1)

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  synchronous reset, active-low
- i_switches  in  OPERAND_SIZE  operand/opcode switches
- i_btn_A  in  1  raw button: load A
- i_btn_B  in  1  raw button: load B
- i_btn_OP  in  1  raw button: load opcode and execute
- i_alu_result  in  OPERAND_SIZE+1  combinational ALU result
- o_data_a  out  OPERAND_SIZE  registered operand A to ALU
- o_data_b  out  OPERAND_SIZE  registered operand B to ALU
- o_op  out  OP_CODE_SIZE  registered opcode to ALU
- o_result  out  OPERAND_SIZE+1  captured result for LEDs
- o_result_valid  out  1  high while o_result holds a result for current A/B/OP
- o_state  out  3  FSM state code

Behaviour:
- Reset (i_rst_n low at a rising edge):
  - o_data_a, o_data_b, o_op, o_result and o_result_valid are cleared to 0.
  - FSM returns to S_A.
  - Sync flops, stable levels, delayed stable levels and debounce counters are cleared to 0.
  - Reset takes effect mid-operation from any state.
- Per button:
  - Two-flop synchronizer (s1, s2).
  - Counter increments each cycle while s2 != stable; it clears to 0 whenever s2 == stable.
  - When s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2 and cnt <= 0.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - Press pulse = stable & ~stable_q (stable_q is stable registered). Pulse is exactly one cycle wide, on rising edges of stable only.
- Latency:
  - Raw input first sampled high at edge k.
  - stable rises at edge k+1+DEBOUNCE_CYCLES.
  - FSM acts at edge k+2+DEBOUNCE_CYCLES, which is DEBOUNCE_CYCLES+3 edges counting k as the first.
  - Glitches shorter than DEBOUNCE_CYCLES cycles (after sync) produce no pulse.
- A button held through reset release yields exactly one press, DEBOUNCE_CYCLES+3 edges after the first edge with i_rst_n high.
- FSM states and o_state encoding:
  - S_A=0: press_A -> o_data_a <= i_switches; go S_B.
  - S_B=1: press_B -> o_data_b <= i_switches; go S_OP.
  - S_OP=2: press_OP -> o_op <= i_switches[OP_CODE_SIZE-1:0]; go S_EXEC.
  - S_EXEC=3: unconditional, one cycle. o_result <= i_alu_result (ALU sees the new o_op this cycle); o_result_valid <= 1; go S_RES.
  - S_RES=4: o_result and o_result_valid hold. press_A -> o_data_a <= i_switches; o_result_valid <= 0; go S_B. o_result keeps its old value until the next S_EXEC.
  - Codes 5..7: unreachable; treat as S_A on the next edge with no register loads.
- Presses not matching the current state are ignored and discarded, not queued. Ignored presses include A in S_B, B in S_A, any press in S_EXEC, and B/OP in S_RES.
- Simultaneous press pulses: only the pulse matching the current state acts; the others are discarded.
- A button held high generates no further pulses until it is released and re-debounced.
- Switch values are sampled only on the accepting edge; later switch changes do not alter o_data_a, o_data_b or o_op.
- o_data_a, o_data_b and o_op hold their values across S_RES; only the loads listed above change them.
- Result width: i_alu_result is captured at full OPERAND_SIZE+1 width (carry bit included), with no truncation.

Test Plan:
All tests use DEBOUNCE_CYCLES=4 and the default widths.
- Reset: hold i_rst_n=0 for 3 cycles with all buttons high, then release. Required: all outputs 0 and o_state=0 during reset. Exactly one A pulse 7 edges after release, loading o_data_a from i_switches.
- Glitch rejection: pulse i_btn_A high for 3 cycles. Required: no state change and o_data_a unchanged. Then hold it high for 10 cycles. Required: o_data_a <= i_switches exactly 7 edges after first sample; o_state 0 -> 1.
- Full sequence:
  - Press A with sw=0x25 and B with sw=0x13.
  - Press OP with sw=0x20; the bench ALU model returns A+B=0x038.
  - Required: o_state steps 1 -> 2 -> 3 -> 4.
  - S_EXEC lasts exactly one cycle.
  - o_result=0x038 and o_result_valid=1 in S_RES.
- Carry capture: with A=0xFF, B=0x01 and model result 0x100, required o_result=0x100 (bit 8 set).
- Out-of-order and simultaneous presses:
  - In S_A, press B then OP. Required: no loads, o_state stays 0.
  - In S_B, press A and B in the same cycle. Required: only o_data_b loads.
- Restart and mid-op reset:
  - In S_RES, press A with sw=0x0F. Required: o_result_valid=0, o_data_a=0x0F, o_state=1, o_result unchanged.
  - Then assert i_rst_n=0 in S_OP. Required: all outputs 0 and o_state=0 on the next edge.
